rx_byte_buffer: RTL

RX_BYTE_BUFFER -- requirements
Module: rx_byte_buffer

---
 rtl/rx_byte_buffer_pkg.sv | 25 ++
 rtl/sync_fifo8.sv | 63 ++++++
 rtl/rx_byte_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/rx_byte_buffer_pkg.sv
// Shared UART constants: capture FSM and receiver state encodings, byte width
// and the write-request payload handed from the capture logic to the FIFO.
package rx_byte_buffer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACK      = 2'b01,
    WAIT_LOW = 2'b10
  } cap_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_START = 2'b01,
    RX_DATA  = 2'b10,
    RX_STOP  = 2'b11
  } rx_state_e;

  typedef struct packed {
    logic              wr;
    logic [BYTE_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/sync_fifo8.sv
// Byte-wide first-word-fall-through FIFO with a separate occupancy counter so
// full and empty never alias when the pointers meet.
module sync_fifo8
  import rx_byte_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk_50m,
  input  logic              reset_n,
  input  wr_req_t           wr_req,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_rd_ok;
  logic              w_wr_ok;

  assign empty   = (r_count == CW'(0));
  assign full    = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous write lands in.
  assign w_rd_ok = rd_en & ~empty;
  assign w_wr_ok = wr_req.wr & (~full | w_rd_ok);

  always_ff @(posedge clk_50m) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= wr_req.data;
    end
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr_ok && w_rd_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/rx_byte_buffer.sv
// Captures each UART receiver byte exactly once, acknowledges it with a
// one-cycle rdy_clr pulse and buffers it in a FIFO with a sticky overflow flag.
module rx_byte_buffer
  import rx_byte_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk_50m,
  input  logic              reset_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rdy_clr,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              ovf_clr
);

  cap_state_e r_state;
  cap_state_e w_state_nxt;
  logic       w_capture;
  logic       w_ovf_evt;
  logic       r_rdy_clr;
  logic       r_overflow;
  wr_req_t    w_wr_req;

  assign rdy_clr  = r_rdy_clr;
  assign overflow = r_overflow;

  // Capture only from IDLE; WAIT_LOW holds off until rx_rdy drops.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_rdy) begin
          w_capture   = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK:      w_state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (!rx_rdy) begin
          w_state_nxt = IDLE;
        end
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_ovf_evt     = w_capture & full & ~rd_en;
  assign w_wr_req.wr   = w_capture;
  assign w_wr_req.data = rx_data;

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rdy_clr  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rdy_clr <= w_capture;
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  sync_fifo8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_50m (clk_50m),
    .reset_n (reset_n),
    .wr_req  (w_wr_req),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule
